// File: rtl/simon_enc_scheduler_if.sv
// Bus between the SIMON encryption scheduler, its cipher wrapper and the key-expansion unit.
// The master side drives requests and round keys; the slave side is the scheduler.
interface simon_enc_scheduler_if #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4,
    parameter int unsigned C = 5
);
    logic               start;
    logic [2*N-1:0]     pt;
    logic [M*N-1:0]     keyIn;
    logic               busy;
    logic [2*N-1:0]     ct;
    logic               ctValid;
    logic               err;
    logic               newKey;
    logic [M*N-1:0]     key;
    logic               ldKey;
    logic [N-1:0]       rKey;
    logic [C:0]         count;
    logic               doneKey;

    modport master (
        output start, pt, keyIn, ldKey, rKey, count, doneKey,
        input  busy, ct, ctValid, err, newKey, key
    );

    modport slave (
        input  start, pt, keyIn, ldKey, rKey, count, doneKey,
        output busy, ct, ctValid, err, newKey, key
    );
endinterface

// File: rtl/simon_enc_scheduler.sv
// Sequences one SIMON 2N/MN block encryption, consuming round keys from the
// key-expansion unit one strobe at a time and checking their order.
module simon_enc_scheduler #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4,
    parameter int unsigned T = 32,
    parameter int unsigned C = 5
) (
    input  logic                  clk,
    input  logic                  R,
    simon_enc_scheduler_if.slave  bus
);

    localparam int unsigned RCW = C + 1;
    localparam int unsigned DW  = 2 * N;
    localparam int unsigned KW  = M * N;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     x_q, x_d;
    logic [N-1:0]     y_q, y_d;
    logic [RCW-1:0]   rc_q, rc_d;
    logic [KW-1:0]    key_q, key_d;
    logic [DW-1:0]    ct_q, ct_d;
    logic             busy_q, busy_d;
    logic             ctv_q, ctv_d;
    logic             err_q, err_d;
    logic             newkey_q, newkey_d;
    logic             abort;

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
        int unsigned sm;
        sm = s % N;
        return (v << sm) | (v >> (N - sm));
    endfunction

    function automatic logic [N-1:0] round_f(input logic [N-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // State register; reset overrides any in-flight run
    always_ff @(posedge clk) begin
        if (R) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            rc_q     <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            busy_q   <= 1'b0;
            ctv_q    <= 1'b0;
            err_q    <= 1'b0;
            newkey_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rc_q     <= rc_d;
            key_q    <= key_d;
            ct_q     <= ct_d;
            busy_q   <= busy_d;
            ctv_q    <= ctv_d;
            err_q    <= err_d;
            newkey_q <= newkey_d;
        end
    end

    // Next state; pulses are computed for the state being entered so outputs stay registered
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rc_d     = rc_q;
        key_d    = key_q;
        ct_d     = ct_q;
        busy_d   = busy_q;
        ctv_d    = 1'b0;
        err_d    = err_q;
        newkey_d = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d      = bus.pt[DW-1:N];
                    y_d      = bus.pt[N-1:0];
                    key_d    = bus.keyIn;
                    err_d    = 1'b0;
                    rc_d     = '0;
                    busy_d   = 1'b1;
                    newkey_d = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.ldKey) begin
                    if (bus.count == rc_q) begin
                        x_d  = y_q ^ round_f(x_q) ^ bus.rKey;
                        y_d  = x_q;
                        rc_d = rc_q + RCW'(1);
                    end else begin
                        abort = 1'b1;
                    end
                end
                // Expansion claiming completion before all rounds arrived
                if (bus.doneKey && (rc_d < RCW'(T))) begin
                    abort = 1'b1;
                end
                if (abort) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (rc_d == RCW'(T)) begin
                    ct_d    = {x_d, y_d};
                    ctv_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.ct      = ct_q;
    assign bus.ctValid = ctv_q;
    assign bus.err     = err_q;
    assign bus.newKey  = newkey_q;
    assign bus.key     = key_q;

endmodule

// File: doc/simon_enc_scheduler.md
Name: simon_enc_scheduler

Overview:
- Sequences one SIMON 2N/MN block encryption (default SIMON32/64) against the team's SIMON key-expansion unit.
- On start, latches plaintext and key and pulses newKey to the expansion unit. Each time a round key arrives, it applies one Feistel round. After T rounds it presents the ciphertext.
- Sits between the top-level cipher wrapper and the key-expansion unit. It owns the round datapath, the round counter and the handshake checking.

Parameters:
N, 16, word size in bits
M, 4, key words
T, 32, number of rounds
C, 5, round-counter MSB index (counter width C+1, must satisfy 2^(C+1) > T)

Ports:
clk  in  1  clock, all state updates on rising edge
R  in  1  reset, synchronous, active-high
start  in  1  request encryption; sampled only in IDLE
pt  in  2N  plaintext {x,y}, x = upper word; latched on accepted start
keyIn  in  M*N  cipher key, word M-1 in the MSBs; latched on accepted start
busy  out  1  high from the cycle after an accepted start until return to IDLE
ct  out  2N  ciphertext {x,y}; holds last result until the next accepted start
ctValid  out  1  one-cycle strobe, ct valid
err  out  1  sticky protocol error; cleared by R or the next accepted start
newKey  out  1  one-cycle pulse to the expansion unit
key  out  M*N  latched key, stable while busy
ldKey  in  1  expansion strobe, rKey/count valid this cycle
rKey  in  N  round key for round count
count  in  C+1  round index of rKey
doneKey  in  1  expansion finished (asserted with or after the last ldKey)

Behaviour:
- Reset (R=1 at an edge): state=IDLE; busy=0, ctValid=0, err=0, newKey=0, ct=0, key=0, round counter rc=0.
- R overrides every state, including mid-run. No ctValid is produced for an aborted run.
- States:
  - IDLE: if start=1, latch pt into {x,y} and keyIn into key, clear err and rc, go to REQ. Otherwise stay.
  - REQ: newKey=1 for exactly this cycle; go to RUN.
  - RUN: on ldKey=1:
    - if count==rc, then x<=y^f(x)^rKey, y<=x, rc<=rc+1;
    - if count!=rc, set err and go to IDLE with no ctValid.
    - When rc reaches T (the update that consumes round T-1), go to DONE.
  - DONE: ct<={x,y}, ctValid=1 for one cycle; go to IDLE.
- Round function: f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x), rotations left modulo N.
- Latency: start edge -> REQ (1) -> RUN. One round per ldKey with no internal stalls. ctValid occurs exactly 1 cycle after the ldKey carrying round T-1.
- doneKey=1 in RUN with rc<T (counting any same-cycle ldKey update) -> set err, go to IDLE.
- doneKey outside RUN is ignored.
- ldKey in IDLE, REQ or DONE is ignored; it has no state change and sets no err.
- start while busy is ignored. start in the same cycle as DONE is ignored; start must be re-sampled in IDLE.
- keyIn/pt changes while busy have no effect.
- Widths: rc is C+1 bits and never wraps, since T < 2^(C+1). x and y are N bits, and all XOR/rotate operations are N-bit.
- busy=1 in REQ, RUN and DONE.

Test Plan:
- Known answer: pt=6565_6877, keyIn=1918_1110_0908_0100, model expansion issuing correct keys 1/cycle -> ctValid with ct=c69b_e9bb; newKey exactly one pulse, 1 cycle after start; busy deasserts after DONE.
- Back-pressured keys: same vectors, ldKey gapped by random 0-5 idle cycles -> identical ct=c69b_e9bb. ctValid exactly 1 cycle after the 32nd ldKey.
- Count mismatch: model skips index 7 (sends count=8 as 8th strobe) -> err=1 that cycle+1, no ctValid, busy=0. Next start clears err and a clean run yields the correct ct.
- Early doneKey: doneKey asserted after 20 ldKeys -> err=1, IDLE, no ctValid. Also drive ldKey in IDLE -> no state change, err stays 0.
- Reset mid-run: assert R after 10 rounds -> next cycle all outputs 0, state IDLE. Subsequent known-answer run passes.
- Start while busy: pulse start with different pt/keyIn during RUN -> ignored; ct=c69b_e9bb from the original inputs; no second newKey.
